// File: rtl/spi_lcd_tx.sv
// SPI mode-0 transmitter for 9-bit display words: bit 8 drives the DC line, bits 7:0 go out MSB first.
// Define SPI_TX_CS_PER_BYTE_EN to deassert CS_n (with a guard gap) after every byte instead of streaming.
module spi_lcd_tx #(
   parameter int CLK_DIV = 2
) (
   input  logic       CLOCK_50,
   input  logic       reset_n,
   input  logic [8:0] i_data,
   input  logic       i_valid,
   output logic       o_ready,
   output logic       o_sclk,
   output logic       o_mosi,
   output logic       o_cs_n,
   output logic       o_dc,
   output logic       o_busy,
   output logic       o_done
);

   localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

`ifdef SPI_TX_CS_PER_BYTE_EN
   localparam logic CS_PER_BYTE = 1'b1;
`else
   localparam logic CS_PER_BYTE = 1'b0;
`endif

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETUP    = 3'd1,
      ST_SHIFT_HI = 3'd2,
      ST_SHIFT_LO = 3'd3,
      ST_HOLD     = 3'd4
`ifdef SPI_TX_CS_PER_BYTE_EN
      , ST_GAP    = 3'd5
`endif
   } state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       bit_q, bit_d;
   logic             last_q, last_d;
   logic [6:0]       shift_q, shift_d;
   logic             sclk_q, sclk_d;
   logic             mosi_q, mosi_d;
   logic             cs_n_q, cs_n_d;
   logic             dc_q, dc_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             ready_q, ready_d;
   logic             accept;

   // Next-state and next-output computation; ready is only ever high in IDLE or the last cycle of a byte.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      last_d  = last_q;
      shift_d = shift_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      cs_n_d  = cs_n_q;
      dc_d    = dc_q;
      accept  = i_valid && ready_q;

      if (accept) begin
         state_d = ST_SETUP;
         div_d   = DIV_LOAD;
         bit_d   = 3'd0;
         last_d  = 1'b0;
         shift_d = i_data[6:0];
         mosi_d  = i_data[7];
         dc_d    = i_data[8];
         cs_n_d  = 1'b0;
         sclk_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               sclk_d = 1'b0;
               cs_n_d = 1'b1;
            end
            ST_SETUP: begin
               if (div_q == DIV_ZERO) begin
                  state_d = ST_SHIFT_HI;
                  sclk_d  = 1'b1;
                  div_d   = DIV_LOAD;
               end else begin
                  div_d = div_q - DIV_ONE;
               end
            end
            ST_SHIFT_HI: begin
               if (div_q == DIV_ZERO) begin
                  state_d = ST_SHIFT_LO;
                  sclk_d  = 1'b0;
                  div_d   = DIV_LOAD;
                  // The eighth fall leaves bit 0 on MOSI and marks the closing low phase.
                  if (bit_q != 3'd7) begin
                     bit_d   = bit_q + 3'd1;
                     mosi_d  = shift_q[6];
                     shift_d = {shift_q[5:0], 1'b0};
                  end else begin
                     last_d = 1'b1;
                  end
               end else begin
                  div_d = div_q - DIV_ONE;
               end
            end
            ST_SHIFT_LO: begin
               if (div_q == DIV_ZERO) begin
                  if (last_q) begin
                     state_d = ST_HOLD;
                     last_d  = 1'b0;
                     div_d   = DIV_LOAD;
                  end else begin
                     state_d = ST_SHIFT_HI;
                     sclk_d  = 1'b1;
                     div_d   = DIV_LOAD;
                  end
               end else begin
                  div_d = div_q - DIV_ONE;
               end
            end
            ST_HOLD: begin
               if (div_q == DIV_ZERO) begin
                  cs_n_d = 1'b1;
`ifdef SPI_TX_CS_PER_BYTE_EN
                  state_d = ST_GAP;
                  div_d   = DIV_LOAD;
`else
                  state_d = ST_IDLE;
`endif
               end else begin
                  div_d = div_q - DIV_ONE;
               end
            end
`ifdef SPI_TX_CS_PER_BYTE_EN
            ST_GAP: begin
               if (div_q == DIV_ZERO) begin
                  state_d = ST_IDLE;
               end else begin
                  div_d = div_q - DIV_ONE;
               end
            end
`endif
            default: begin
               state_d = ST_IDLE;
               sclk_d  = 1'b0;
               cs_n_d  = 1'b1;
               last_d  = 1'b0;
            end
         endcase
      end

      done_d  = (state_d == ST_SHIFT_LO) && last_d && (div_d == DIV_ZERO);
      ready_d = (state_d == ST_IDLE) || (done_d && !CS_PER_BYTE);
      busy_d  = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous active-low reset; a reset drops any byte in flight.
   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         div_q   <= DIV_ZERO;
         bit_q   <= 3'd0;
         last_q  <= 1'b0;
         shift_q <= 7'd0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         dc_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         last_q  <= last_d;
         shift_q <= shift_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         cs_n_q  <= cs_n_d;
         dc_q    <= dc_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ready_q <= ready_d;
      end
   end

   assign o_ready = ready_q;
   assign o_sclk  = sclk_q;
   assign o_mosi  = mosi_q;
   assign o_cs_n  = cs_n_q;
   assign o_dc    = dc_q;
   assign o_busy  = busy_q;
   assign o_done  = done_q;

endmodule

// File: tb/tb_spi_lcd_tx.sv
// Directed bench for spi_lcd_tx: a D=2 instance and a D=1 instance, observed on the falling clock edge.
module tb_spi_lcd_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [8:0] d2, d1;
   logic       v2, v1;
   logic       r2, sclk2, mosi2, cs2, dc2, busy2, done2;
   logic       r1, sclk1, mosi1, cs1, dc1, busy1, done1;

   spi_lcd_tx #(.CLK_DIV(2)) dut2 (
      .CLOCK_50(clk), .reset_n(rst_n), .i_data(d2), .i_valid(v2), .o_ready(r2),
      .o_sclk(sclk2), .o_mosi(mosi2), .o_cs_n(cs2), .o_dc(dc2), .o_busy(busy2), .o_done(done2)
   );

   spi_lcd_tx #(.CLK_DIV(1)) dut1 (
      .CLOCK_50(clk), .reset_n(rst_n), .i_data(d1), .i_valid(v1), .o_ready(r1),
      .o_sclk(sclk1), .o_mosi(mosi1), .o_cs_n(cs1), .o_dc(dc1), .o_busy(busy1), .o_done(done1)
   );

`ifdef SPI_TX_CS_PER_BYTE_EN
   localparam int STREAM_PER = 39;
   localparam int STREAM_CS  = 36;
   localparam int BP_PER     = 39;
`else
   localparam int STREAM_PER = 34;
   localparam int STREAM_CS  = 104;
   localparam int BP_PER     = 37;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int         n_acc2, rise_n2, rise_first2, rise_last2, done_n2, done_cyc2, cs_hi_cyc2, viol2;
   int         acc_cyc2 [0:3];
   logic       acc_dc2 [0:3];
   logic [7:0] rx2;
   logic [7:0] rx_hist2 [0:3];
   logic       p_sclk2, p_mosi2, p_dc2, p_cs2;

   int         n_acc1, rise_n1, rise_first1, rise_last1, done_n1, done_cyc1, cs_hi_cyc1;
   int         acc_cyc1;
   logic [7:0] rx1;
   logic       p_sclk1, p_cs1;

   int         e0;
   logic [8:0] words [0:2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_mon();
      n_acc2 = 0; rise_n2 = 0; rise_first2 = -1; rise_last2 = -1;
      done_n2 = 0; done_cyc2 = -1; cs_hi_cyc2 = -1; viol2 = 0; rx2 = 8'h00;
      for (int i = 0; i < 4; i++) begin
         acc_cyc2[i] = -1; acc_dc2[i] = 1'bx; rx_hist2[i] = 8'hxx;
      end
      p_sclk2 = sclk2; p_mosi2 = mosi2; p_dc2 = dc2; p_cs2 = cs2;
      n_acc1 = 0; rise_n1 = 0; rise_first1 = -1; rise_last1 = -1;
      done_n1 = 0; done_cyc1 = -1; cs_hi_cyc1 = -1; acc_cyc1 = -1; rx1 = 8'h00;
      p_sclk1 = sclk1; p_cs1 = cs1;
   endtask

   // One clock: note pending accepts, wait for the falling edge, then record what both DUTs show.
   task automatic tick();
      logic a2, a1;
      a2 = v2 && r2;
      a1 = v1 && r1;
      @(negedge clk);
      cyc++;
      if (a2 && n_acc2 < 4) begin
         acc_cyc2[n_acc2] = cyc;
         acc_dc2[n_acc2]  = dc2;
         n_acc2++;
      end
      if (sclk2 && !p_sclk2) begin
         if (rise_n2 == 0) rise_first2 = cyc;
         rise_last2 = cyc;
         rx2 = {rx2[6:0], mosi2};
         rise_n2++;
         if ((rise_n2 % 8) == 0 && rise_n2 <= 32) rx_hist2[rise_n2 / 8 - 1] = rx2;
      end
      if (sclk2 && p_sclk2 && (mosi2 !== p_mosi2 || dc2 !== p_dc2)) viol2++;
      if (done2) begin
         done_n2++;
         done_cyc2 = cyc;
      end
      if (cs2 && !p_cs2 && cs_hi_cyc2 < 0) cs_hi_cyc2 = cyc;
      p_sclk2 = sclk2; p_mosi2 = mosi2; p_dc2 = dc2; p_cs2 = cs2;

      if (a1) begin
         acc_cyc1 = cyc;
         n_acc1++;
      end
      if (sclk1 && !p_sclk1) begin
         if (rise_n1 == 0) rise_first1 = cyc;
         rise_last1 = cyc;
         rx1 = {rx1[6:0], mosi1};
         rise_n1++;
      end
      if (done1) begin
         done_n1++;
         done_cyc1 = cyc;
      end
      if (cs1 && !p_cs1 && cs_hi_cyc1 < 0) cs_hi_cyc1 = cyc;
      p_sclk1 = sclk1; p_cs1 = cs1;
   endtask

   initial begin
      rst_n = 1'b0;
      d2 = 9'h000; v2 = 1'b0;
      d1 = 9'h000; v1 = 1'b0;
      words[0] = 9'h03A; words[1] = 9'h155; words[2] = 9'h0FF;

      // Reset values
      repeat (3) tick();
      chk("rst_sclk", sclk2, 1'b0);
      chk("rst_mosi", mosi2, 1'b0);
      chk("rst_cs_n", cs2, 1'b1);
      chk("rst_dc", dc2, 1'b0);
      chk("rst_busy", busy2, 1'b0);
      chk("rst_done", done2, 1'b0);
      chk("rst_ready", r2, 1'b0);
      rst_n = 1'b1;
      tick();
      chk("ready_after_rel_d2", r2, 1'b1);
      chk("ready_after_rel_d1", r1, 1'b1);

      // Single word 0x1A5, D=2
      clr_mon();
      d2 = 9'h1A5; v2 = 1'b1;
      tick();
      v2 = 1'b0; d2 = 9'h000;
      e0 = acc_cyc2[0];
      chk("single_accepts", n_acc2, 1);
      chk("single_acc_cs_n", cs2, 1'b0);
      chk("single_acc_dc", dc2, 1'b1);
      chk("single_acc_mosi", mosi2, 1'b1);
      chk("single_acc_ready", r2, 1'b0);
      chk("single_acc_busy", busy2, 1'b1);
      repeat (40) tick();
      chk("single_rises", rise_n2, 8);
      chk("single_byte", rx_hist2[0], 8'hA5);
      chk("single_rise_first", rise_first2, e0 + 2);
      chk("single_rise_last", rise_last2, e0 + 30);
      chk("single_done_n", done_n2, 1);
      chk("single_done_cyc", done_cyc2, e0 + 33);
      chk("single_cs_hi", cs_hi_cyc2, e0 + 36);
      chk("single_viol", viol2, 0);
      chk("single_end_ready", r2, 1'b1);
      chk("single_end_busy", busy2, 1'b0);

      // Three words with i_valid held high
      clr_mon();
      d2 = words[0]; v2 = 1'b1;
      for (int t = 0; t < 140; t++) begin
         tick();
         if (n_acc2 < 3) d2 = words[n_acc2];
         else v2 = 1'b0;
      end
      v2 = 1'b0;
      e0 = acc_cyc2[0];
      chk("stream_accepts", n_acc2, 3);
      chk("stream_per1", acc_cyc2[1] - e0, STREAM_PER);
      chk("stream_per2", acc_cyc2[2] - e0, 2 * STREAM_PER);
      chk("stream_dc0", acc_dc2[0], 1'b0);
      chk("stream_dc1", acc_dc2[1], 1'b1);
      chk("stream_dc2", acc_dc2[2], 1'b0);
      chk("stream_byte0", rx_hist2[0], 8'h3A);
      chk("stream_byte1", rx_hist2[1], 8'h55);
      chk("stream_byte2", rx_hist2[2], 8'hFF);
      chk("stream_done_n", done_n2, 3);
      chk("stream_cs_hi", cs_hi_cyc2, e0 + STREAM_CS);
      chk("stream_viol", viol2, 0);

      // Backpressure: i_valid toggles every cycle with a different word waiting
      clr_mon();
      d2 = 9'h0C3; v2 = 1'b1;
      tick();
      d2 = 9'h13C;
      for (int t = 1; t < 60 && n_acc2 < 2; t++) begin
         v2 = t[0];
         tick();
      end
      v2 = 1'b0;
      repeat (45) tick();
      e0 = acc_cyc2[0];
      chk("bp_accepts", n_acc2, 2);
      chk("bp_second_acc", acc_cyc2[1] - e0, BP_PER);
      chk("bp_byte0", rx_hist2[0], 8'hC3);
      chk("bp_dc0", acc_dc2[0], 1'b0);
      chk("bp_byte1", rx_hist2[1], 8'h3C);
      chk("bp_dc1", acc_dc2[1], 1'b1);
      chk("bp_done_n", done_n2, 2);

      // D=1, word 0x100
      clr_mon();
      d1 = 9'h100; v1 = 1'b1;
      tick();
      v1 = 1'b0; d1 = 9'h000;
      e0 = acc_cyc1;
      chk("d1_accepts", n_acc1, 1);
      chk("d1_acc_dc", dc1, 1'b1);
      repeat (25) tick();
      chk("d1_rises", rise_n1, 8);
      chk("d1_byte", rx1, 8'h00);
      chk("d1_rise_first", rise_first1, e0 + 1);
      chk("d1_rise_last", rise_last1, e0 + 15);
      chk("d1_done_n", done_n1, 1);
      chk("d1_done_cyc", done_cyc1, e0 + 16);
      chk("d1_cs_hi", cs_hi_cyc1, e0 + 18);

      // Reset in the middle of a byte
      clr_mon();
      d2 = 9'h1FF; v2 = 1'b1;
      tick();
      v2 = 1'b0;
      e0 = acc_cyc2[0];
      repeat (8) tick();
      chk("mid_before_cs_n", cs2, 1'b0);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_cyc", cyc, e0 + 9);
      chk("mid_rst_cs_n", cs2, 1'b1);
      chk("mid_rst_sclk", sclk2, 1'b0);
      chk("mid_rst_mosi", mosi2, 1'b0);
      chk("mid_rst_done", done2, 1'b0);
      chk("mid_rst_ready", r2, 1'b0);
      chk("mid_rst_busy", busy2, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("mid_rel_ready", r2, 1'b1);
      repeat (40) tick();
      chk("mid_no_done", done_n2, 0);
      chk("mid_idle_cs_n", cs2, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_lcd_tx.md
Name: spi_lcd_tx

Overview:
SPI transmitter that serialises 9-bit display words ({mode/DC bit, data byte}) onto a 3-signal SPI bus (SCLK, MOSI, CS_n) plus a DC line, driving the panel-side SPI link. It sits downstream of the frame/command buffer, which offers words over a valid/ready handshake. It is the sending end of the 9-bit word format consumed by the SPI receive buffer: bit 8 is the mode bit and bits 7:0 are the payload.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first.

Parameters:
CLK_DIV, 2, SCLK half-period in CLOCK_50 cycles (D); legal range 1..255.

Ports:
CLOCK_50  input  1  system clock; all logic is on the rising edge.
reset_n  input  1  synchronous, active-low reset.
i_data  input  9  [8]=mode (driven to o_dc), [7:0]=byte to send.
i_valid  input  1  i_data is valid.
o_ready  output  1  block accepts i_data on this edge if i_valid=1.
o_sclk  output  1  SPI clock, idles low.
o_mosi  output  1  serial data, MSB first.
o_cs_n  output  1  chip select, active low.
o_dc  output  1  data/command line; holds the latched mode bit.
o_busy  output  1  high whenever the state is not IDLE.
o_done  output  1  one-cycle pulse when a byte completes.

Behaviour:
- One clock (CLOCK_50). Reset is synchronous, active-low (reset_n). All outputs are registered.
- Reset (any edge with reset_n=0, including mid-byte): state=IDLE, o_sclk=0, o_mosi=0, o_cs_n=1, o_dc=0, o_busy=0, o_done=0, o_ready=0. The in-flight byte is dropped and no o_done is issued. o_ready=1 from the first edge after reset_n returns high.
- States: IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD. A 3-bit bit counter and a CLK_DIV counter sized to hold D run alongside.
- Accept: a transfer starts on an edge E0 where i_valid and o_ready are both 1. At E0:
  - latch shift register = i_data[7:0]
  - o_dc = i_data[8]
  - o_mosi = i_data[7]
  - o_cs_n = 0, o_sclk = 0
  - o_ready = 0
- SETUP lasts D cycles. For k=0..7:
  - o_sclk rises at E0+(2k+1)D (SHIFT_HI) and falls at E0+(2k+2)D (SHIFT_LO).
  - On falls with k<7, o_mosi shifts to the next lower bit. After the 8th fall, o_mosi holds bit 0.
- The final SHIFT_LO runs to E0+17D. During the cycle ending at E0+17D, o_done=1 and o_ready=1.
- Streaming: if i_valid=1 at E0+17D, the next word is accepted and E0'=E0+17D. o_cs_n stays 0 and o_dc/o_mosi update at E0'. The streaming byte period is exactly 17D cycles.
- If there is no accept at E0+17D: HOLD keeps o_cs_n=0 and o_sclk=0 for D cycles. At E0+18D, o_cs_n=1 and the state returns to IDLE with o_ready=1.
- o_ready=0 in SETUP, SHIFT_HI, HOLD, and in SHIFT_LO except the final cycle of bit 7.
- i_data and i_valid are ignored when not accepted; i_valid may drop without an accept. o_dc and o_mosi never change while o_sclk=1.

Optional Feature:
SPI_TX_CS_PER_BYTE_EN
- Defined:
  - o_ready is NOT asserted at the end of bit 7; o_done is still pulsed at E0+17D.
  - Every byte goes through HOLD. At E0+18D o_cs_n=1, then a GAP state holds o_cs_n=1 for D cycles.
  - IDLE with o_ready=1 follows at E0+19D. The minimum byte period is 19D+1 cycles.
- Undefined: streaming as described in Behaviour; no GAP state.

Test Plan:
- Single word, D=2: i_data=0x1A5 accepted at E0 -> o_dc=1; MOSI sampled on rises at E0+2,6,...,30 reads 1,0,1,0,0,1,0,1; o_done at E0+34; o_cs_n=1 at E0+36.
- Stream, D=2: 0x03A, 0x155, 0x0FF with i_valid held -> accepts at E0, E0+34, E0+68; o_cs_n low continuously; o_dc 0,1,0; three o_done pulses.
- Backpressure: i_valid toggled every cycle during a byte -> no extra accepts; only the accept at E0+17D or IDLE is taken; the word is unchanged on the wire.
- D=1: 0x100 -> 8 zero bits, rises at E0+1,3,...,15; o_done at E0+17; o_cs_n=1 at E0+18.
- Reset mid-byte: assert reset_n=0 at E0+9 (D=2) -> next edge: o_cs_n=1, o_sclk=0, o_mosi=0, no o_done; o_ready=1 one edge after release.
- With SPI_TX_CS_PER_BYTE_EN, D=2, two words back-to-back -> o_cs_n high from E0+36 to E0+38; second accept at E0+38 or later.
